alert_qual: RTL and testbench
=============================

Name: alert_qual

Overview:
Qualifies raw battery and wheel-speed samples into clean, debounced `too_fast` and `batt_low` alert flags for the piezo alert driver.
- Sits directly upstream of the piezo driver.
- Applies threshold comparison, hysteresis, consecutive-sample persistence and a minimum on-time, so the tune sequencer never sees glitching or chattering alert inputs.
- Samples are consumed only on a valid strobe from the A2D/speed path.

Parameters:
- `fast_sim`, 1, when 1 shortens `MIN_HOLD` to 2^12 clocks; when 0, `MIN_HOLD` is 2^21 clocks (~42 ms at 50 MHz).
- `SPD_SET`, 12'd1536, speed-magnitude threshold above which a sample counts toward `too_fast`.
- `SPD_HYST`, 12'd128, a sample counts toward clearing `too_fast` when magnitude < `SPD_SET - SPD_HYST`.
- `BATT_SET`, 12'h800, a sample counts toward `batt_low` when `batt < BATT_SET`.
- `BATT_CLR`, 12'h880, a sample counts toward clearing `batt_low` when `batt >= BATT_CLR`.
- `PERSIST`, 4, number of consecutive qualifying samples required for any set or clear; range 1..15.

Ports:
- `clk` in 1: system clock, 50 MHz.
- `rst_n` in 1: asynchronous active-low reset.
- `vld` in 1: one-cycle strobe; `batt`, `lft_spd` and `rght_spd` are valid this cycle.
- `batt` in 12: unsigned battery voltage sample.
- `lft_spd` in 12: signed left wheel speed.
- `rght_spd` in 12: signed right wheel speed.
- `too_fast` out 1: registered qualified over-speed alert.
- `batt_low` out 1: registered qualified low-battery alert.

Behaviour:

Reset and clocking
- One clock, `clk`. Reset is asynchronous and active-low on `rst_n`.
- Reset values: `too_fast`=0, `batt_low`=0, both FSMs in OK, all persistence counters 0, hold timer 0 (expired).

Speed magnitude
- `mag = max(|lft_spd|, |rght_spd|)`, computed 13 bits wide, so -2048 gives 2048 with no overflow.
- Comparisons against `SPD_SET` and `SPD_SET - SPD_HYST` are unsigned 13-bit.

Sampling rules
- Inputs are evaluated only in cycles with `vld`=1. Non-`vld` cycles leave FSM state and counters unchanged.
- Exception: the hold timer decrements every clock, independent of `vld`.

FSMs
- There are two independent FSMs, SPD and BATT, each with states OK, PEND_SET, ALERT, PEND_CLR.
- OK: a set-qualifying sample loads cnt=1. If `PERSIST`=1, go to ALERT; otherwise go to PEND_SET.
- PEND_SET:
  - A set-qualifying sample increments cnt; when cnt reaches `PERSIST`, go to ALERT.
  - Any non-qualifying sample (including hysteresis-band samples) returns to OK with cnt=0.
- ALERT:
  - A clear-qualifying sample loads cnt=1 and goes to PEND_CLR.
  - If `PERSIST`=1, go straight to OK, subject to the hold rule below.
  - Hysteresis-band or set-qualifying samples stay in ALERT.
- PEND_CLR:
  - A clear-qualifying sample increments cnt, saturating at `PERSIST`.
  - A non-clear sample returns to ALERT with cnt=0.
  - When cnt equals `PERSIST` and the clear condition is met, go to OK.

Outputs and timing
- Each output is 1 in states ALERT and PEND_CLR and 0 in OK and PEND_SET.
- Outputs are registered. The flag changes on the clock edge that ends the `vld` cycle completing the count, i.e. it is visible the cycle after that strobe.

Minimum hold (SPD only)
- On the OK/PEND_SET→ALERT transition, the hold timer loads `MIN_HOLD`-1 and counts down to 0, saturating at 0.
- SPD may not leave PEND_CLR for OK while the timer is nonzero. Clear-qualifying samples keep cnt saturated at `PERSIST`.
- The first `vld` sample after expiry that is still clear-qualifying completes the transition to OK.
- BATT has no hold timer.

Boundary cases
- `mag == SPD_SET` does not qualify for set.
- `batt == BATT_SET` does not qualify for set.
- `batt == BATT_CLR` qualifies for clear.
- Counter widths are 4 bits and never wrap.
- Reset asserted mid-pending or mid-hold returns everything to reset values immediately, with no glitch on the outputs beyond the asynchronous clear.

Test Plan:
1. Speed set: reset; 4 `vld` samples, `lft_spd`=1600, `rght_spd`=0 → `too_fast`=1 the cycle after the 4th `vld`; after only 3 samples it stays 0.
2. Broken persistence: 3 samples at `mag`=1600, 1 sample at `mag`=1500 (band), then 3 at 1600 → `too_fast` stays 0; a 4th sample at 1600 then asserts it.
3. Negative speed and hold: `rght_spd`=-2048 ×4 → `too_fast`=1. Then `mag`=0 samples every 16 clocks → `too_fast` remains 1 until the first `vld` after 4096 clocks from assertion, then 0 the next cycle.
4. Battery hysteresis: `batt`=0x7FF ×4 → `batt_low`=1. `batt`=0x850 ×10 → stays 1. `batt`=0x880 ×4 → 0 after the 4th.
5. Boundary: `batt`=0x800 ×8 → `batt_low`=0; `mag`=1536 ×8 → `too_fast`=0. Non-`vld` cycles with `batt`=0 → no change.
6. Reset mid-operation: assert `rst_n`=0 in PEND_SET and during the hold window → outputs 0 immediately; after release, a full 4-sample sequence is again required.

Source files
------------

// File: rtl/alert_qual_if.sv
// Sample/alert bundle between the A2D/speed path, the qualifier and the piezo driver.
// The master drives raw samples with a valid strobe; the slave returns qualified alerts.
interface alert_qual_if;
  logic               vld;
  logic        [11:0] batt;
  logic signed [11:0] lft_spd;
  logic signed [11:0] rght_spd;
  logic               too_fast;
  logic               batt_low;

  modport master (
    output vld, batt, lft_spd, rght_spd,
    input  too_fast, batt_low
  );

  modport slave (
    input  vld, batt, lft_spd, rght_spd,
    output too_fast, batt_low
  );
endinterface

// File: rtl/alert_qual.sv
// Turns raw battery / wheel-speed samples into debounced too_fast and batt_low flags
// using thresholds, hysteresis, consecutive-sample persistence and a minimum speed-alert on-time.
module alert_qual #(
  parameter bit          fast_sim = 1'b1,
  parameter logic [11:0] SPD_SET  = 12'd1536,
  parameter logic [11:0] SPD_HYST = 12'd128,
  parameter logic [11:0] BATT_SET = 12'h800,
  parameter logic [11:0] BATT_CLR = 12'h880,
  parameter int          PERSIST  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  alert_qual_if.slave  bus
);

  typedef enum logic [1:0] {OK, PEND_SET, ALERT, PEND_CLR} state_t;

  localparam logic [3:0]  PERS      = 4'(PERSIST);
  localparam logic [20:0] HOLD_LOAD = fast_sim ? 21'd4095 : 21'h1F_FFFF;
  localparam logic [12:0] SET_TH    = {1'b0, SPD_SET};
  localparam logic [12:0] CLR_TH    = {1'b0, SPD_SET - SPD_HYST};

  // One extra bit so that -2048 maps to +2048 without overflow.
  function automatic logic [12:0] abs13(input logic signed [11:0] x);
    logic signed [12:0] s;
    s = {x[11], x};
    abs13 = s[12] ? $unsigned(-s) : $unsigned(s);
  endfunction

  function automatic logic [12:0] max13(input logic [12:0] a, input logic [12:0] b);
    max13 = (a > b) ? a : b;
  endfunction

  // Persistence counter increment that holds at PERS and can never wrap.
  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    sat_inc = (c >= PERS) ? PERS : c + 4'd1;
  endfunction

  // ---- sample evaluation (combinational, consumed on vld) ----
  logic        vld_p0;
  logic [12:0] mag_p0;
  logic        spd_set_p0, spd_clr_p0;
  logic        batt_set_p0, batt_clr_p0;

  assign vld_p0      = bus.vld;
  assign mag_p0      = max13(abs13(bus.lft_spd), abs13(bus.rght_spd));
  assign spd_set_p0  = mag_p0 > SET_TH;
  assign spd_clr_p0  = mag_p0 < CLR_TH;
  assign batt_set_p0 = bus.batt < BATT_SET;
  assign batt_clr_p0 = bus.batt >= BATT_CLR;

  // ---- speed qualifier with minimum on-time ----
  state_t      spd_st;
  logic [3:0]  spd_cnt;
  logic [20:0] hold;
  logic        too_fast_q;
  logic [3:0]  spd_nxt;

  assign spd_nxt = sat_inc(spd_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spd_st     <= OK;
      spd_cnt    <= 4'd0;
      hold       <= 21'd0;
      too_fast_q <= 1'b0;
    end else begin
      // Hold timer runs every clock; an ALERT entry below overrides with a reload.
      if (hold != 21'd0) hold <= hold - 21'd1;
      if (vld_p0) begin
        unique case (spd_st)
          OK: begin
            if (spd_set_p0) begin
              spd_cnt <= 4'd1;
              if (PERS == 4'd1) begin
                spd_st     <= ALERT;
                hold       <= HOLD_LOAD;
                too_fast_q <= 1'b1;
              end else begin
                spd_st <= PEND_SET;
              end
            end
          end
          PEND_SET: begin
            if (spd_set_p0) begin
              if (spd_nxt == PERS) begin
                spd_st     <= ALERT;
                spd_cnt    <= 4'd0;
                hold       <= HOLD_LOAD;
                too_fast_q <= 1'b1;
              end else begin
                spd_cnt <= spd_nxt;
              end
            end else begin
              spd_st  <= OK;
              spd_cnt <= 4'd0;
            end
          end
          ALERT: begin
            if (spd_clr_p0) begin
              if (PERS == 4'd1 && hold == 21'd0) begin
                spd_st     <= OK;
                spd_cnt    <= 4'd0;
                too_fast_q <= 1'b0;
              end else begin
                spd_st  <= PEND_CLR;
                spd_cnt <= 4'd1;
              end
            end
          end
          PEND_CLR: begin
            if (spd_clr_p0) begin
              // A live hold timer parks us here with the count saturated.
              if (spd_nxt == PERS && hold == 21'd0) begin
                spd_st     <= OK;
                spd_cnt    <= 4'd0;
                too_fast_q <= 1'b0;
              end else begin
                spd_cnt <= spd_nxt;
              end
            end else begin
              spd_st  <= ALERT;
              spd_cnt <= 4'd0;
            end
          end
        endcase
      end
    end
  end

  // ---- battery qualifier ----
  state_t     batt_st;
  logic [3:0] batt_cnt;
  logic       batt_low_q;
  logic [3:0] batt_nxt;

  assign batt_nxt = sat_inc(batt_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      batt_st    <= OK;
      batt_cnt   <= 4'd0;
      batt_low_q <= 1'b0;
    end else if (vld_p0) begin
      unique case (batt_st)
        OK: begin
          if (batt_set_p0) begin
            batt_cnt <= 4'd1;
            if (PERS == 4'd1) begin
              batt_st    <= ALERT;
              batt_low_q <= 1'b1;
            end else begin
              batt_st <= PEND_SET;
            end
          end
        end
        PEND_SET: begin
          if (batt_set_p0) begin
            if (batt_nxt == PERS) begin
              batt_st    <= ALERT;
              batt_cnt   <= 4'd0;
              batt_low_q <= 1'b1;
            end else begin
              batt_cnt <= batt_nxt;
            end
          end else begin
            batt_st  <= OK;
            batt_cnt <= 4'd0;
          end
        end
        ALERT: begin
          if (batt_clr_p0) begin
            if (PERS == 4'd1) begin
              batt_st    <= OK;
              batt_cnt   <= 4'd0;
              batt_low_q <= 1'b0;
            end else begin
              batt_st  <= PEND_CLR;
              batt_cnt <= 4'd1;
            end
          end
        end
        PEND_CLR: begin
          if (batt_clr_p0) begin
            if (batt_nxt == PERS) begin
              batt_st    <= OK;
              batt_cnt   <= 4'd0;
              batt_low_q <= 1'b0;
            end else begin
              batt_cnt <= batt_nxt;
            end
          end else begin
            batt_st  <= ALERT;
            batt_cnt <= 4'd0;
          end
        end
      endcase
    end
  end

  assign bus.too_fast = too_fast_q;
  assign bus.batt_low = batt_low_q;

endmodule

// File: tb/tb_alert_qual.sv
// Bench for alert_qual: vector table, hand sequences for hold/reset corners, and a
// randomized run compared against a run-length reference model of the qualification rules.
module tb_alert_qual;

  localparam int P        = 4;
  localparam int MIN_HOLD = 4096;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alert_qual_if bus ();
  alert_qual dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int passes = 0;

  // Reference model: alert flag plus the length of the current qualifying run.
  int e_cnt = 0;
  int load_e = -1000000;
  bit m_tf, m_bl;
  int run_spd, run_bl;

  typedef struct {
    bit                 rs;
    logic               v;
    logic        [11:0] b;
    logic signed [11:0] l;
    logic signed [11:0] r;
    logic               tf;
    logic               bl;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string nm, input logic act, input logic exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
  endtask

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic model_reset();
    m_tf = 0; m_bl = 0; run_spd = 0; run_bl = 0; load_e = -1000000;
  endtask

  task automatic model_step(input logic v, input logic [11:0] b,
                            input logic signed [11:0] l, input logic signed [11:0] r);
    int li, ri, mag, bi;
    e_cnt++;
    if (!v) return;
    li = l; ri = r; bi = b;
    mag = (iabs(li) > iabs(ri)) ? iabs(li) : iabs(ri);
    if (!m_tf) begin
      if (mag > 1536) begin
        run_spd++;
        if (run_spd == P) begin m_tf = 1; run_spd = 0; load_e = e_cnt; end
      end else run_spd = 0;
    end else begin
      if (mag < 1408) begin
        if (run_spd < P) run_spd++;
        if (run_spd == P && (e_cnt - load_e) >= MIN_HOLD) begin m_tf = 0; run_spd = 0; end
      end else run_spd = 0;
    end
    if (!m_bl) begin
      if (bi < 'h800) begin
        run_bl++;
        if (run_bl == P) begin m_bl = 1; run_bl = 0; end
      end else run_bl = 0;
    end else begin
      if (bi >= 'h880) begin
        if (run_bl < P) run_bl++;
        if (run_bl == P) begin m_bl = 0; run_bl = 0; end
      end else run_bl = 0;
    end
  endtask

  // Called just after a rising edge; drives one cycle of inputs and checks against the model.
  task automatic tick(input logic v, input logic [11:0] b,
                      input logic signed [11:0] l, input logic signed [11:0] r);
    bus.vld = v; bus.batt = b; bus.lft_spd = l; bus.rght_spd = r;
    @(posedge clk);
    model_step(v, b, l, r);
    #1;
    check("model_too_fast", bus.too_fast, m_tf);
    check("model_batt_low", bus.batt_low, m_bl);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check("rst_too_fast", bus.too_fast, 1'b0);
    check("rst_batt_low", bus.batt_low, 1'b0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(bit rs, logic v, logic [11:0] b, logic signed [11:0] l,
                              logic signed [11:0] r, logic tf, logic bl);
    vec_t x;
    x.rs = rs; x.v = v; x.b = b; x.l = l; x.r = r; x.tf = tf; x.bl = bl;
    return x;
  endfunction

  function automatic logic signed [11:0] pick_spd(input int rg);
    int m;
    case (rg)
      0:       m = $urandom_range(2048, 1537);
      1:       m = $urandom_range(1536, 1408);
      default: m = $urandom_range(1407, 0);
    endcase
    if (m == 2048 || $urandom_range(1, 0) == 1) m = -m;
    return 12'(m);
  endfunction

  function automatic logic [11:0] pick_batt(input int rg);
    case (rg)
      0:       return 12'($urandom_range(12'h7FF, 0));
      1:       return 12'($urandom_range(12'h87F, 12'h800));
      default: return 12'($urandom_range(12'hFFF, 12'h880));
    endcase
  endfunction

  initial begin
    int high;
    bit dropped;
    int srg, brg;

    rst_n = 1'b0;
    bus.vld = 1'b0; bus.batt = 12'h0; bus.lft_spd = '0; bus.rght_spd = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_too_fast", bus.too_fast, 1'b0);
    check("reset_batt_low", bus.batt_low, 1'b0);
    rst_n = 1'b1;

    // Speed set, idle cycles, broken persistence, boundary values.
    tbl.push_back(mk(1, 1, 12'hA00, 1600, 0, 0, 0));
    tbl.push_back(mk(0, 1, 12'hA00, 1600, 0, 0, 0));
    tbl.push_back(mk(0, 1, 12'hA00, 1600, 0, 0, 0));
    tbl.push_back(mk(0, 0, 12'hA00, 1600, 0, 0, 0));
    tbl.push_back(mk(0, 1, 12'hA00, 1600, 0, 1, 0));
    tbl.push_back(mk(1, 1, 12'hA00, 1600, 0, 0, 0));
    tbl.push_back(mk(0, 1, 12'hA00, 1600, 0, 0, 0));
    tbl.push_back(mk(0, 1, 12'hA00, 1600, 0, 0, 0));
    tbl.push_back(mk(0, 1, 12'hA00, 1500, 0, 0, 0));
    tbl.push_back(mk(0, 1, 12'hA00, 0, -1600, 0, 0));
    tbl.push_back(mk(0, 1, 12'hA00, 0, -1600, 0, 0));
    tbl.push_back(mk(0, 1, 12'hA00, 0, -1600, 0, 0));
    tbl.push_back(mk(0, 1, 12'hA00, 0, -1600, 1, 0));
    tbl.push_back(mk(1, 1, 12'h800, 0, 0, 0, 0));
    for (int i = 0; i < 7; i++) tbl.push_back(mk(0, 1, 12'h800, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++) tbl.push_back(mk(0, 1, 12'hA00, 1536, -1536, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 1, 12'h7FF, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 12'h000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 12'h7FF, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 12'h000, 0, 0, 0, 1));

    foreach (tbl[i]) begin
      if (tbl[i].rs) do_reset();
      tick(tbl[i].v, tbl[i].b, tbl[i].l, tbl[i].r);
      check($sformatf("vec%0d_too_fast", i), bus.too_fast, tbl[i].tf);
      check($sformatf("vec%0d_batt_low", i), bus.batt_low, tbl[i].bl);
    end

    // Full-scale negative speed, then minimum on-time with slow clear samples.
    do_reset();
    for (int i = 0; i < 4; i++) tick(1, 12'hA00, 0, -2048);
    check("neg2048_set", bus.too_fast, 1'b1);
    high = 1;
    dropped = 0;
    for (int i = 1; i <= 5000 && !dropped; i++) begin
      tick((i % 16) == 0, 12'hA00, 0, 0);
      if (bus.too_fast) high++;
      else dropped = 1;
    end
    checks++;
    if (dropped && high == MIN_HOLD) passes++;
    else $display("FAIL hold_duration: high for %0d cycles (dropped=%0d) expected %0d", high, dropped, MIN_HOLD);

    // Battery hysteresis band.
    do_reset();
    for (int i = 0; i < 4; i++) tick(1, 12'h7FF, 0, 0);
    check("batt_set", bus.batt_low, 1'b1);
    for (int i = 0; i < 10; i++) tick(1, 12'h850, 0, 0);
    check("batt_band_hold", bus.batt_low, 1'b1);
    for (int i = 0; i < 3; i++) tick(1, 12'h880, 0, 0);
    check("batt_clr_3", bus.batt_low, 1'b1);
    tick(1, 12'h880, 0, 0);
    check("batt_clr_4", bus.batt_low, 1'b0);

    // Reset in PEND_SET and during the hold window.
    do_reset();
    for (int i = 0; i < 2; i++) tick(1, 12'hA00, 1600, 0);
    do_reset();
    for (int i = 0; i < 3; i++) tick(1, 12'hA00, 1600, 0);
    check("after_rst_pend_3", bus.too_fast, 1'b0);
    for (int i = 0; i < 4; i++) tick(1, 12'h100, 1600, 0);
    check("pre_hold_rst_tf", bus.too_fast, 1'b1);
    check("pre_hold_rst_bl", bus.batt_low, 1'b1);
    repeat (100) tick(0, 12'h100, 0, 0);
    do_reset();
    for (int i = 0; i < 3; i++) tick(1, 12'hA00, 1600, 0);
    check("after_rst_hold_3", bus.too_fast, 1'b0);
    tick(1, 12'hA00, 1600, 0);
    check("after_rst_hold_4", bus.too_fast, 1'b1);

    // Randomized regimes near the thresholds.
    do_reset();
    srg = 2; brg = 2;
    for (int i = 0; i < 6000; i++) begin
      logic signed [11:0] a, o;
      logic [11:0] bv;
      if ((i % 24) == 0) begin
        srg = $urandom_range(2, 0);
        brg = $urandom_range(2, 0);
      end
      a  = pick_spd(($urandom_range(7, 0) == 0) ? int'($urandom_range(2, 0)) : srg);
      o  = pick_spd(2);
      bv = pick_batt(($urandom_range(7, 0) == 0) ? int'($urandom_range(2, 0)) : brg);
      if ($urandom_range(1, 0) == 1) tick($urandom_range(2, 0) != 0, bv, a, o);
      else                           tick($urandom_range(2, 0) != 0, bv, o, a);
      if ($urandom_range(1499, 0) == 0) do_reset();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
